// File: rtl/generador_secuencia_pkg.sv
// Shared constants, state encoding and note helper for the note-sequence generator.
// SECUENCIA_FIJA exists only when SECUENCIA_FIJA_EN is defined.
package generador_secuencia_pkg;

  localparam int ANCHO_NOTA = 3;
  localparam int NUM_NOTAS  = 10;
  localparam int ANCHO_BUS  = ANCHO_NOTA * NUM_NOTAS;

  localparam logic [15:0] SEMILLA_LFSR = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] TAPS_LFSR    = 16'b1011_0100_0000_0000;

`ifdef SECUENCIA_FIJA_EN
  localparam logic [ANCHO_BUS-1:0] SECUENCIA_FIJA = 30'b111101111101111101111101111101;
`endif

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    GENERANDO = 2'd1,
    LISTO     = 2'd2
  } estado_t;

  function automatic logic [ANCHO_NOTA-1:0] remap_nota(input logic [ANCHO_NOTA-1:0] valor);
    return (valor == '0) ? 3'b001 : valor;
  endfunction

endpackage

// File: rtl/lfsr_notas.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low bits as a never-zero 3-bit note.
module lfsr_notas
  import generador_secuencia_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [ANCHO_NOTA-1:0] nota
);

  logic [15:0] lfsr;
  logic        realim;

  assign realim = ^(lfsr & TAPS_LFSR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= SEMILLA_LFSR;
    else        lfsr <= {lfsr[14:0], realim};
  end

  assign nota = remap_nota(lfsr[ANCHO_NOTA-1:0]);

endmodule

// File: rtl/generador_secuencia.sv
// Generates a ten-note sequence on each rising edge of cargarSecuencia.
// Define SECUENCIA_FIJA_EN to take notes from a fixed table instead of the LFSR.
module generador_secuencia
  import generador_secuencia_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cargarSecuencia,
  output logic [ANCHO_BUS-1:0] busNotas,
  output logic                 secuenciaLista,
  output logic                 ocupado
);

  estado_t     estado, estado_sig;
  logic [3:0]  contador;
  logic        cargar_prev;
  logic        armado;
  logic        pedido;

`ifndef SECUENCIA_FIJA_EN
  logic [ANCHO_NOTA-1:0] nota;

  lfsr_notas u_lfsr (
    .clk   (clk),
    .reset (reset),
    .nota  (nota)
  );
`endif

  // A level already high at reset release must go low before it can count as a request
  assign pedido  = cargarSecuencia & ~cargar_prev & armado;
  assign ocupado = (estado == GENERANDO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cargar_prev <= 1'b0;
      armado      <= 1'b0;
    end else begin
      cargar_prev <= cargarSecuencia;
      if (!cargarSecuencia) armado <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO, LISTO: if (pedido) estado_sig = GENERANDO;
      GENERANDO: begin
        if (contador > 4'd9)       estado_sig = REPOSO;
        else if (contador == 4'd9) estado_sig = LISTO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contador       <= 4'd0;
      busNotas       <= '0;
      secuenciaLista <= 1'b0;
    end else begin
      case (estado)
        REPOSO, LISTO: begin
          if (pedido) begin
            contador       <= 4'd0;
            secuenciaLista <= 1'b0;
          end
        end
        GENERANDO: begin
          if (contador > 4'd9) begin
            contador       <= 4'd0;
            secuenciaLista <= 1'b0;
          end else begin
            for (int i = 0; i < NUM_NOTAS; i++) begin
              if (contador == 4'(i)) begin
`ifdef SECUENCIA_FIJA_EN
                busNotas[ANCHO_NOTA*i +: ANCHO_NOTA] <= SECUENCIA_FIJA[ANCHO_NOTA*i +: ANCHO_NOTA];
`else
                busNotas[ANCHO_NOTA*i +: ANCHO_NOTA] <= nota;
`endif
              end
            end
            contador <= contador + 4'd1;
            if (contador == 4'd9) secuenciaLista <= 1'b1;
          end
        end
        default: begin
          contador       <= 4'd0;
          secuenciaLista <= 1'b0;
        end
      endcase
    end
  end

endmodule
